// File: rtl/serial_add_sub.sv
// serial_add_sub: multi-cycle adder/subtractor. It processes two WIDTH-bit operands
// LSB-first, DIGIT bits per clock, through a DIGIT-bit ripple-carry slice. Control is a
// start/busy/done handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      request; accepted in IDLE or DONE only
//   mode       1 = add (a + b), 0 = subtract (a - b); sampled with start
//   a, b       WIDTH-bit operands; sampled with start
//   busy       high while an operation is running
//   done       one-cycle pulse when result/carry_out/overflow are updated
//   result     registered result, held until the next completion
//   carry_out  carry from the MSB (subtract: 1 = no borrow)
//   overflow   two's-complement signed overflow
module serial_add_sub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned NumDigits = WIDTH / DIGIT;
  localparam int unsigned CntW      = (NumDigits > 1) ? $clog2(NumDigits) : 1;

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_add_sub: WIDTH must be >= 2 and an integer multiple of DIGIT");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q, acc_q, acc_d;
  logic              mode_q, carry_q;
  logic [CntW-1:0]   cnt_q;
  logic [DIGIT-1:0]  b_sel, sum;
  logic [DIGIT:0]    c;
  logic              accept, last;

  assign accept = start && (state_q != StRun);
  assign last   = (cnt_q == CntW'(NumDigits - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last)  state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
  end

  // Ripple-carry slice over the low DIGIT bits; subtract uses ~b with carry-in seeded to 1.
  always_comb begin
    b_sel = mode_q ? b_q[DIGIT-1:0] : ~b_q[DIGIT-1:0];
    sum   = '0;
    c     = '0;
    c[0]  = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]  = a_q[i] ^ b_sel[i] ^ c[i];
      c[i+1]  = (a_q[i] & b_sel[i]) | (a_q[i] & c[i]) | (b_sel[i] & c[i]);
    end
    // New digit enters at the MSB end so the final digit lands the word in place.
    acc_d = (acc_q >> DIGIT) | (WIDTH'(sum) << (WIDTH - DIGIT));
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      mode_q    <= 1'b0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      acc_q   <= '0;
      mode_q  <= mode;
      carry_q <= ~mode;
      cnt_q   <= '0;
    end else if (state_q == StRun) begin
      a_q     <= a_q >> DIGIT;
      b_q     <= b_q >> DIGIT;
      acc_q   <= acc_d;
      carry_q <= c[DIGIT];
      cnt_q   <= cnt_q + CntW'(1);
      if (last) begin
        result    <= acc_d;
        carry_out <= c[DIGIT];
        // Carry into the MSB differs from carry out of it exactly on signed overflow.
        overflow  <= c[DIGIT] ^ c[DIGIT-1];
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
module tb_serial_add_sub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start8, mode8, busy8, done8, co8, ov8;
  logic [7:0]  a8, b8, res8;
  logic        start16, mode16, busy16, done16, co16, ov16;
  logic [15:0] a16, b16, res16;

  int total = 0;
  int bad   = 0;

  serial_add_sub #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .carry_out(co8), .overflow(ov8)
  );

  serial_add_sub #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .mode(mode16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(res16), .carry_out(co16), .overflow(ov16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular arithmetic. Returns {overflow, carry_out, result[31:0]}.
  function automatic logic [33:0] model(input int w, input logic m,
                                        input logic [31:0] x, input logic [31:0] y);
    longint unsigned xx, yy, mask, bb, full, r;
    logic sa, sb, sr, co, ov;
    xx   = 64'(x);
    yy   = 64'(y);
    mask = (64'd1 << w) - 64'd1;
    bb   = m ? yy : (~yy & mask);
    full = xx + bb + (m ? 64'd0 : 64'd1);
    r    = full & mask;
    co   = full[w];
    sa   = xx[w-1];
    sb   = bb[w-1];
    sr   = r[w-1];
    ov   = (sa == sb) && (sr != sa);
    return {ov, co, r[31:0]};
  endfunction

  // Called one negedge after start was taken; counts remaining busy cycles up to done.
  task automatic finish8(input string tag, input int nb_exp, input logic [33:0] e);
    int nb = 0;
    int cyc = 0;
    logic both = 1'b0;
    while (done8 !== 1'b1 && cyc < 40) begin
      if (busy8 === 1'b1) nb++;
      if (busy8 === 1'b1 && done8 === 1'b1) both = 1'b1;
      cyc++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, nb, nb_exp);
    check({tag, "_done"}, {31'b0, done8}, 1);
    check({tag, "_busy_low"}, {31'b0, busy8 | both}, 0);
    check({tag, "_result"}, {24'b0, res8}, e[31:0]);
    check({tag, "_carry"}, {31'b0, co8}, {31'b0, e[32]});
    check({tag, "_ovf"}, {31'b0, ov8}, {31'b0, e[33]});
  endtask

  task automatic op8(input logic m, input logic [7:0] x, input logic [7:0] y, input string tag);
    @(negedge clk);
    start8 = 1'b1; mode8 = m; a8 = x; b8 = y;
    @(negedge clk);
    start8 = 1'b0;
    finish8(tag, 8, model(8, m, {24'b0, x}, {24'b0, y}));
  endtask

  task automatic op16(input logic m, input logic [15:0] x, input logic [15:0] y,
                      input string tag);
    logic [33:0] e;
    int nb = 0;
    int cyc = 0;
    e = model(16, m, {16'b0, x}, {16'b0, y});
    @(negedge clk);
    start16 = 1'b1; mode16 = m; a16 = x; b16 = y;
    @(negedge clk);
    start16 = 1'b0;
    while (done16 !== 1'b1 && cyc < 40) begin
      if (busy16 === 1'b1) nb++;
      cyc++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, nb, 4);
    check({tag, "_done"}, {31'b0, done16}, 1);
    check({tag, "_result"}, {16'b0, res16}, e[31:0]);
    check({tag, "_carry"}, {31'b0, co16}, {31'b0, e[32]});
    check({tag, "_ovf"}, {31'b0, ov16}, {31'b0, e[33]});
  endtask

  initial begin
    int ndone;
    logic [7:0] rx, ry;
    logic [15:0] rx16, ry16;
    logic rm;

    rst = 1'b1;
    start8 = 1'b0; mode8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; mode16 = 1'b0; a16 = '0; b16 = '0;
    #12;
    check("rst_busy", {31'b0, busy8}, 0);
    check("rst_done", {31'b0, done8}, 0);
    check("rst_result", {24'b0, res8}, 0);
    check("rst_flags", {30'b0, co8, ov8}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed arithmetic cases
    op8(1'b1, 8'd100, 8'd27, "add_100_27");
    op8(1'b1, 8'd100, 8'd100, "add_100_100");
    op8(1'b1, 8'd200, 8'd100, "add_200_100");
    op8(1'b0, 8'd5, 8'd7, "sub_5_7");
    op8(1'b0, 8'h80, 8'h01, "sub_80_01");

    // Done is a single-cycle pulse and outputs hold afterwards
    @(negedge clk);
    check("done_pulse_width", {31'b0, done8}, 0);
    repeat (3) @(negedge clk);
    check("result_hold", {24'b0, res8}, 32'h7f);
    check("carry_hold", {31'b0, co8}, 1);

    // Start and operand changes during RUN are ignored
    @(negedge clk);
    start8 = 1'b1; mode8 = 1'b1; a8 = 8'd10; b8 = 8'd3;
    @(negedge clk);
    a8 = 8'd50; b8 = 8'd50;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    a8 = 8'd77; b8 = 8'd200; mode8 = 1'b0;
    finish8("ignore_run", 6, model(8, 1'b1, 32'd10, 32'd3));

    // Back-to-back start in the done cycle
    start8 = 1'b1; mode8 = 1'b1; a8 = 8'd50; b8 = 8'd50;
    @(negedge clk);
    start8 = 1'b0;
    check("b2b_busy_immediate", {31'b0, busy8}, 1);
    finish8("b2b", 8, model(8, 1'b1, 32'd50, 32'd50));

    // Asynchronous reset mid-RUN
    @(negedge clk);
    start8 = 1'b1; mode8 = 1'b1; a8 = 8'h33; b8 = 8'h44;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy8}, 0);
    check("abort_done", {31'b0, done8}, 0);
    check("abort_result", {24'b0, res8}, 0);
    check("abort_flags", {30'b0, co8, ov8}, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) ndone++;
    end
    check("abort_no_done", ndone, 0);
    op8(1'b1, 8'd1, 8'd1, "fresh_1_1");

    // Randomised 8-bit operations
    for (int i = 0; i < 15; i++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      rm = 1'($urandom);
      op8(rm, rx, ry, $sformatf("rand8_%0d", i));
    end

    // 16-bit, 4 bits per cycle
    op16(1'b0, 16'h1234, 16'h0235, "sub16_1234_0235");
    for (int i = 0; i < 10; i++) begin
      rx16 = 16'($urandom);
      ry16 = 16'($urandom);
      rm   = 1'($urandom);
      op16(rm, rx16, ry16, $sformatf("rand16_%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
